// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared definitions for the DAC clock activity monitor:
//   - clk_mon_state_e      : hysteresis FSM states
//   - DEF_* localparams    : default parameter values for the monitor
//   - clk_mon_window_good  : decides whether a closed window counts as "good"
// -----------------------------------------------------------------------------
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_ABSENT  = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_PRESENT = 2'd2
  } clk_mon_state_e;

  localparam int DEF_WINDOW_CYCLES   = 256;
  localparam int DEF_MIN_EDGES       = 16;
  localparam int DEF_MAX_EDGES       = 200;
  localparam int DEF_PRESENT_WINDOWS = 3;
  localparam int DEF_ABSENT_WINDOWS  = 1;
  localparam int DEF_CNT_W           = 16;

  // The upper bound only applies when range_en is set; otherwise any count at
  // or above min_edges (including a saturated count) is good.
  function automatic logic clk_mon_window_good(
    input logic [31:0] ecnt_final,
    input logic [31:0] min_edges,
    input logic [31:0] max_edges,
    input logic        range_en
  );
    clk_mon_window_good = (ecnt_final >= min_edges) &&
                          (!range_en || (ecnt_final <= max_edges));
  endfunction

endpackage

// File: rtl/clk_mon_sync_edge.sv
// -----------------------------------------------------------------------------
// clk_mon_sync_edge
// Brings the asynchronous dac_clk toggle into the pcie_clk domain with a 2-flop
// synchronizer, then a delay flop turns every toggle transition (rising or
// falling) into a one-cycle edge pulse.
// Ports:
//   i_clk  : pcie_clk
//   i_rst  : asynchronous active-high reset
//   i_tog  : toggle from the dac_clk domain
//   o_edge : one-cycle pulse per toggle transition
// -----------------------------------------------------------------------------
module clk_mon_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tog,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_dly;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= i_tog;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign o_edge = r_sync2 ^ r_dly;

endmodule

// File: rtl/dac_clk_activity_monitor.sv
// -----------------------------------------------------------------------------
// dac_clk_activity_monitor
// Qualifies the DAC clock before the clock-select FSM may switch to it. Edges of
// the divided dac_clk toggle are counted over fixed pcie_clk windows; window
// results pass through present/absent hysteresis.
// Build option: DAC_CLK_MON_RANGE_CHECK_EN adds an upper bound (MAX_EDGES) to
// the good-window test so an over-frequency clock is rejected.
// Ports:
//   pcie_clk        : the only clock
//   reset           : asynchronous active-high reset
//   dac_clk_tog     : toggle from the dac_clk domain (asynchronous)
//   enable          : level; 0 holds the monitor idle and cleared
//   dac_clk_present : qualified-present flag
//   dac_clk_lost    : one-cycle pulse on the present->absent transition
//   window_done     : one-cycle pulse when a window closes
//   edge_count      : edge count of the last closed window
// -----------------------------------------------------------------------------
module dac_clk_activity_monitor
  import clk_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
  parameter int MIN_EDGES       = DEF_MIN_EDGES,
  parameter int MAX_EDGES       = DEF_MAX_EDGES,
  parameter int PRESENT_WINDOWS = DEF_PRESENT_WINDOWS,
  parameter int ABSENT_WINDOWS  = DEF_ABSENT_WINDOWS,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             pcie_clk,
  input  logic             reset,
  input  logic             dac_clk_tog,
  input  logic             enable,
  output logic             dac_clk_present,
  output logic             dac_clk_lost,
  output logic             window_done,
  output logic [CNT_W-1:0] edge_count
);

`ifdef DAC_CLK_MON_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  logic             w_edge;
  logic             w_close;
  logic             w_good;
  logic [CNT_W-1:0] w_ecnt_final;

  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_ecnt;

  clk_mon_state_e   r_state;
  clk_mon_state_e   w_state_nxt;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] w_good_nxt;
  logic [CNT_W-1:0] r_bad_cnt;
  logic [CNT_W-1:0] w_bad_nxt;

  logic             r_done;
  logic             r_lost;
  logic [CNT_W-1:0] r_edge_count;
  logic             w_done_nxt;
  logic             w_lost_nxt;
  logic [CNT_W-1:0] w_edge_count_nxt;

  clk_mon_sync_edge u_sync_edge (
    .i_clk  (pcie_clk),
    .i_rst  (reset),
    .i_tog  (dac_clk_tog),
    .o_edge (w_edge)
  );

  // Gating the close with enable lets an enable drop in the closing cycle
  // discard the window result.
  assign w_close = enable && (r_wcnt == CNT_W'(WINDOW_CYCLES - 1));

  // The edge of the closing cycle is folded into the final count.
  assign w_ecnt_final = (w_edge && (r_ecnt != '1)) ? r_ecnt + 1'b1 : r_ecnt;

  assign w_good = clk_mon_window_good(32'(w_ecnt_final), 32'(MIN_EDGES),
                                      32'(MAX_EDGES), RANGE_EN);

  always_ff @(posedge pcie_clk or posedge reset) begin
    if (reset) begin
      r_wcnt <= '0;
      r_ecnt <= '0;
    end else if (!enable) begin
      r_wcnt <= '0;
      r_ecnt <= '0;
    end else if (w_close) begin
      r_wcnt <= '0;
      r_ecnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 1'b1;
      r_ecnt <= w_ecnt_final;
    end
  end

  // State register
  always_ff @(posedge pcie_clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ABSENT;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
    end
  end

  // Next state: advances only on window close
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    if (!enable) begin
      w_state_nxt = ST_ABSENT;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
    end else if (w_close) begin
      unique case (r_state)
        ST_ABSENT: begin
          if (w_good) begin
            if (PRESENT_WINDOWS == 1) begin
              w_state_nxt = ST_PRESENT;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_state_nxt = ST_QUALIFY;
              w_good_nxt  = CNT_W'(1);
            end
          end
        end
        ST_QUALIFY: begin
          if (w_good) begin
            if ((r_good_cnt + 1'b1) == CNT_W'(PRESENT_WINDOWS)) begin
              w_state_nxt = ST_PRESENT;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_good_nxt = r_good_cnt + 1'b1;
            end
          end else begin
            w_state_nxt = ST_ABSENT;
            w_good_nxt  = '0;
          end
        end
        ST_PRESENT: begin
          if (w_good) begin
            w_bad_nxt = '0;
          end else if ((r_bad_cnt + 1'b1) == CNT_W'(ABSENT_WINDOWS)) begin
            w_state_nxt = ST_ABSENT;
            w_bad_nxt   = '0;
          end else begin
            w_bad_nxt = r_bad_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_ABSENT;
          w_good_nxt  = '0;
          w_bad_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs: computed here, registered below so they all move together.
  // Loss only fires through a window close, never through an enable drop.
  always_comb begin
    w_done_nxt       = w_close;
    w_lost_nxt       = w_close && (r_state == ST_PRESENT) &&
                       (w_state_nxt == ST_ABSENT);
    w_edge_count_nxt = r_edge_count;
    if (!enable) begin
      w_edge_count_nxt = '0;
    end else if (w_close) begin
      w_edge_count_nxt = w_ecnt_final;
    end
  end

  always_ff @(posedge pcie_clk or posedge reset) begin
    if (reset) begin
      r_done       <= 1'b0;
      r_lost       <= 1'b0;
      r_edge_count <= '0;
    end else begin
      r_done       <= w_done_nxt;
      r_lost       <= w_lost_nxt;
      r_edge_count <= w_edge_count_nxt;
    end
  end

  assign dac_clk_present = (r_state == ST_PRESENT);
  assign dac_clk_lost    = r_lost;
  assign window_done     = r_done;
  assign edge_count      = r_edge_count;

endmodule

// File: tb/tb_dac_clk_activity_monitor.sv
module tb_dac_clk_activity_monitor;

  localparam int WIN  = 256;
  localparam int MINE = 16;
  localparam int MAXE = 100;
  localparam int PW   = 3;
  localparam int AW   = 1;
`ifdef DAC_CLK_MON_RANGE_CHECK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  logic        pcie_clk    = 1'b0;
  logic        reset       = 1'b1;
  logic        dac_clk_tog = 1'b0;
  logic        enable      = 1'b0;
  logic        dac_clk_present;
  logic        dac_clk_lost;
  logic        window_done;
  logic [15:0] edge_count;

  dac_clk_activity_monitor #(
    .WINDOW_CYCLES   (WIN),
    .MIN_EDGES       (MINE),
    .MAX_EDGES       (MAXE),
    .PRESENT_WINDOWS (PW),
    .ABSENT_WINDOWS  (AW),
    .CNT_W           (16)
  ) dut (
    .pcie_clk        (pcie_clk),
    .reset           (reset),
    .dac_clk_tog     (dac_clk_tog),
    .enable          (enable),
    .dac_clk_present (dac_clk_present),
    .dac_clk_lost    (dac_clk_lost),
    .window_done     (window_done),
    .edge_count      (edge_count)
  );

  always #5 pcie_clk = ~pcie_clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int g_sp     = 0;
  int pat[8];
  int lost_pulses = 0;

  // reference model: tog history, window tallies, run lengths of good/bad windows
  bit h0, h1, h2, h3;
  int m_wc, m_ecnt, m_grun, m_brun, m_ec;
  bit m_present, m_wd, m_lost;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  task automatic model_step();
    bit e, good;
    int fin;
    if (reset) begin
      h0 = 0; h1 = 0; h2 = 0; h3 = 0;
      m_wc = 0; m_ecnt = 0; m_grun = 0; m_brun = 0; m_ec = 0;
      m_present = 0; m_wd = 0; m_lost = 0;
    end else begin
      h3 = h2; h2 = h1; h1 = h0; h0 = dac_clk_tog;
      e = h2 ^ h3;   // toggle change seen two samples late
      m_wd = 0; m_lost = 0;
      if (!enable) begin
        m_wc = 0; m_ecnt = 0; m_grun = 0; m_brun = 0; m_ec = 0; m_present = 0;
      end else begin
        if (e && m_ecnt < 65535) m_ecnt++;
        m_wc++;
        if (m_wc == WIN) begin
          fin    = m_ecnt;
          m_wc   = 0;
          m_ecnt = 0;
          good   = (fin >= MINE) && (!RCHK || fin <= MAXE);
          m_wd   = 1;
          m_ec   = fin;
          if (!m_present) begin
            m_grun = good ? m_grun + 1 : 0;
            if (m_grun >= PW) begin
              m_present = 1; m_grun = 0; m_brun = 0;
            end
          end else begin
            m_brun = good ? 0 : m_brun + 1;
            if (m_brun >= AW) begin
              m_present = 0; m_lost = 1; m_brun = 0;
            end
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge pcie_clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge pcie_clk);
    if (!reset) begin
      chk("cmp_window_done", window_done, m_wd);
      chk("cmp_edge_count", edge_count, m_ec);
      chk("cmp_present", dac_clk_present, m_present);
      chk("cmp_lost", dac_clk_lost, m_lost);
      if (dac_clk_lost) lost_pulses++;
    end
  end

  // toggle pattern: within window w, flip at positions 0, sp, 2sp, ... (pat[w] flips)
  task automatic drive_tog();
    int wp, w;
    if (enable && g_sp > 0) begin
      wp = (cyc - 1) % WIN;
      w  = (cyc - 1) / WIN;
      if (w > 7) w = 7;
      if ((wp % g_sp) == 0 && (wp / g_sp) < pat[w]) dac_clk_tog = ~dac_clk_tog;
    end
  endtask

  task automatic set_pat(input int sp, input int n);
    g_sp = sp;
    for (int i = 0; i < 8; i++) pat[i] = n;
  endtask

  task automatic start_en();
    @(negedge pcie_clk);
    enable = 1'b1;
    cyc = 1;
    drive_tog();
  endtask

  task automatic step();
    @(negedge pcie_clk);
    cyc++;
    drive_tog();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic go_idle(input int k);
    @(negedge pcie_clk);
    enable = 1'b0;
    repeat (k) @(negedge pcie_clk);
    chk("idle_present", dac_clk_present, 0);
    chk("idle_edge_count", edge_count, 0);
  endtask

  initial begin
    int lp0, nwin;
    repeat (3) @(negedge pcie_clk);
    chk("rst_present", dac_clk_present, 0);
    chk("rst_lost", dac_clk_lost, 0);
    chk("rst_window_done", window_done, 0);
    chk("rst_edge_count", edge_count, 0);
    reset = 1'b0;

    // no toggles
    set_pat(0, 0);
    start_en();
    run_to(256);  chk("A_no_done_early", window_done, 0);
    run_to(257);  chk("A_done1", window_done, 1); chk("A_cnt1", edge_count, 0);
    run_to(258);  chk("A_done_pulse", window_done, 0);
    run_to(513);  chk("A_done2", window_done, 1);
    run_to(769);  chk("A_present", dac_clk_present, 0);

    // 64 edges/window, then stop
    go_idle(4);
    set_pat(4, 64);
    start_en();
    run_to(513);  chk("B_cnt64", edge_count, 64);
    run_to(768);  chk("B_not_yet", dac_clk_present, 0);
    g_sp = 0;
    run_to(769);  chk("B_present_769", dac_clk_present, 1); chk("B_done3", window_done, 1);
    run_to(1024); chk("B_still_present", dac_clk_present, 1);
    run_to(1025); chk("B_lost", dac_clk_lost, 1); chk("B_dropped", dac_clk_present, 0);
    chk("B_cnt_low", edge_count, 0);
    run_to(1026); chk("B_lost_one_cycle", dac_clk_lost, 0);
    run_to(1030); chk("B_lost_count", lost_pulses, 1);

    // 15 edges/window never qualifies
    go_idle(4);
    set_pat(16, 15);
    start_en();
    for (int w = 1; w <= 5; w++) begin
      run_to(WIN * w + 1);
      chk("C_cnt15", edge_count, 15);
    end
    chk("C_never_present", dac_clk_present, 0);

    // 16 edges/window qualifies after 3
    go_idle(4);
    set_pat(16, 16);
    start_en();
    run_to(768);  chk("D_not_yet", dac_clk_present, 0);
    run_to(769);  chk("D_present", dac_clk_present, 1); chk("D_cnt16", edge_count, 16);

    // good, bad, good, good, good
    go_idle(4);
    set_pat(4, 64);
    pat[1] = 0;
    start_en();
    run_to(513);  chk("E_bad_cnt", edge_count, 0);
    run_to(1025); chk("E_not_at_4", dac_clk_present, 0);
    run_to(1281); chk("E_present_at_5", dac_clk_present, 1);

    // 128 edges/window: rejected only with the range check
    go_idle(4);
    set_pat(2, 128);
    start_en();
    run_to(769);  chk("F_cnt128", edge_count, 128);
    chk("F_present", dac_clk_present, RCHK ? 0 : 1);
    run_to(1025); chk("F_present_later", dac_clk_present, RCHK ? 0 : 1);

    // enable drop in QUALIFY, then full requalification
    go_idle(4);
    lp0 = lost_pulses;
    set_pat(4, 64);
    start_en();
    run_to(514);
    enable = 1'b0;
    repeat (3) @(negedge pcie_clk);
    chk("G_present", dac_clk_present, 0);
    chk("G_cnt", edge_count, 0);
    chk("G_done", window_done, 0);
    chk("G_no_lost", lost_pulses, lp0);
    start_en();
    run_to(513);  chk("G_requal_2", dac_clk_present, 0);
    run_to(769);  chk("G_requal_3", dac_clk_present, 1);
    // enable drop in the closing cycle discards the window
    run_to(1024);
    enable = 1'b0;
    @(negedge pcie_clk);
    chk("G2_no_done", window_done, 0);
    chk("G2_cnt", edge_count, 0);
    chk("G2_present", dac_clk_present, 0);
    chk("G2_no_lost", dac_clk_lost, 0);

    // async reset in PRESENT
    go_idle(4);
    lp0 = lost_pulses;
    set_pat(4, 64);
    start_en();
    run_to(800);  chk("H_present", dac_clk_present, 1);
    #2 reset = 1'b1;
    #1;
    chk("H_rst_present", dac_clk_present, 0);
    chk("H_rst_lost", dac_clk_lost, 0);
    chk("H_rst_done", window_done, 0);
    chk("H_rst_cnt", edge_count, 0);
    repeat (2) @(negedge pcie_clk);
    reset = 1'b0;
    cyc = 1;
    drive_tog();
    run_to(768);  chk("H_requal_wait", dac_clk_present, 0);
    run_to(769);  chk("H_requal", dac_clk_present, 1);
    chk("H_no_lost", lost_pulses, lp0);

    // randomized segments, checked every cycle by the model
    for (int it = 0; it < 12; it++) begin
      go_idle(3 + int'($urandom_range(0, 5)));
      g_sp = int'($urandom_range(2, 24));
      for (int i = 0; i < 8; i++)
        pat[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(12, 20))
                                             : int'($urandom_range(0, WIN / g_sp + 1));
      start_en();
      nwin = int'($urandom_range(1, 5));
      run_to(nwin * WIN + int'($urandom_range(1, WIN)));
      if (it % 4 == 3) begin
        #3 reset = 1'b1;
        @(negedge pcie_clk);
        reset = 1'b0;
        cyc = 1;
        drive_tog();
        run_to(int'($urandom_range(300, 900)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_clk_activity_monitor.md
# dac_clk_activity_monitor

Single-clock detector in the `pcie_clk` domain that qualifies whether the DAC clock is alive before the clock-select FSM / MMCM input mux switches to it. It counts edges of a divided toggle derived from `dac_clk` over fixed measurement windows. It applies hysteresis across consecutive windows and reports `dac_clk_present`, a one-shot `dac_clk_lost`, and the last window's edge count. The block sits directly upstream of the clock-select FSM.

## Interface
- `WINDOW_CYCLES`, 256: `pcie_clk` cycles per measurement window (≥ 4).
- `MIN_EDGES`, 16: minimum edges in a window for it to be "good".
- `MAX_EDGES`, 200: maximum edges for a good window; used only with the range-check macro.
- `PRESENT_WINDOWS`, 3: consecutive good windows required to assert present (≥ 1).
- `ABSENT_WINDOWS`, 1: consecutive bad windows required to deassert present (≥ 1).
- `CNT_W`, 16: width of the edge and window counters.

Ports:
- `pcie_clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `dac_clk_tog` in 1: toggle generated from `dac_clk` in its own domain. Its toggle rate must be < `pcie_clk`/4. It is asynchronous to `pcie_clk`.
- `enable` in 1: level input. When 0, the monitor is held idle.
- `dac_clk_present` out 1: qualified-present flag.
- `dac_clk_lost` out 1: one-cycle pulse on the PRESENT→ABSENT transition.
- `window_done` out 1: one-cycle pulse when a window closes.
- `edge_count` out `CNT_W`: edge count of the last closed window.

## Operation
- Input path: a 2-flop synchronizer followed by a delay flop. `edge = sync2 ^ dly`, so both toggle edges count. Latency from a `dac_clk_tog` change to the `edge` pulse is 2–3 cycles.
- Window counter `wcnt` counts 0..`WINDOW_CYCLES`-1 while `enable`=1, then wraps to 0.
- Edge counter `ecnt` increments on each `edge` and saturates at 2^`CNT_W`-1.
- The edge arriving in the closing cycle (`wcnt`=`WINDOW_CYCLES`-1) is included in that window.
- The next window starts at `ecnt`=0. No edge is lost or double-counted across the boundary.
- A window is good when `ecnt_final` ≥ `MIN_EDGES`. With range check enabled, it must also satisfy `ecnt_final` ≤ `MAX_EDGES`.
- The FSM advances only on window close.
  - ABSENT: a good window moves to PRESENT if `PRESENT_WINDOWS`=1, otherwise to QUALIFY with `good_cnt`=1. A bad window stays in ABSENT.
  - QUALIFY: a good window increments `good_cnt`. When `good_cnt` reaches `PRESENT_WINDOWS`, go to PRESENT. A bad window returns to ABSENT and clears `good_cnt`.
  - PRESENT: a bad window increments `bad_cnt`. When `bad_cnt` reaches `ABSENT_WINDOWS`, go to ABSENT and pulse `dac_clk_lost`. A good window clears `bad_cnt`.
- `enable`=0 synchronously clears `wcnt`, `ecnt`, `good_cnt`, `bad_cnt` and `edge_count`, and forces ABSENT. No `dac_clk_lost` pulse is produced. The synchronizer flops keep running.
- Reset: all state and outputs go to 0 and the FSM goes to ABSENT.

## Timing
- `window_done`, `edge_count`, `dac_clk_present` and `dac_clk_lost` are all registered. They update together, one cycle after the closing cycle.
- The first window starts on the first cycle with `enable`=1 after reset, or after `enable` rises.
- Earliest present: `PRESENT_WINDOWS`×`WINDOW_CYCLES`+1 cycles after enable, when toggles are present from the start.
- Loss detection is at most (`ABSENT_WINDOWS`+1)×`WINDOW_CYCLES`+1 cycles after the toggles stop.
- An `enable` drop in the same cycle as a window close takes priority: the window result is discarded.
- Reset asserted mid-QUALIFY or mid-PRESENT clears everything immediately (asynchronously).

## Configuration
- `DAC_CLK_MON_RANGE_CHECK_EN` defined: a good window also requires `ecnt_final` ≤ `MAX_EDGES`. An over-frequency window is bad.
- Not defined: there is no upper bound, and `MAX_EDGES` is ignored. Saturation still applies.

## Structure
- Package `clk_mon_pkg` holds:
  - the FSM state enum (ABSENT, QUALIFY, PRESENT);
  - the default parameter constants;
  - the `clk_mon_window_good` function.
- Sub-module `clk_mon_sync_edge` contains the 2-flop synchronizer, the delay flop and the `edge` output, with async reset to 0.

## Test plan
- Reset with `enable`=1 and no toggles → outputs 0. `window_done` pulses every 256 cycles with `edge_count`=0. Present never asserts.
- Toggle every 4 cycles (64 edges/window) → `edge_count`=64. Present rises with the 3rd `window_done`, at cycle 769 after enable.
- While present, stop toggles → `dac_clk_lost` is a one-cycle pulse and present drops at the first window close reporting < 16 edges.
- Boundary: 15 edges/window never qualifies. 16 edges/window qualifies after 3 windows. A good, bad, good, good, good pattern asserts present only at the 5th window.
- With `DAC_CLK_MON_RANGE_CHECK_EN` and `MAX_EDGES`=100, toggle every 2 cycles (128 edges) → never present. Without the macro → present after 3 windows.
- Drop `enable` in QUALIFY, and separately assert `reset` in PRESENT → ABSENT, counters and `edge_count` at 0, no `dac_clk_lost` pulse. Re-enable → full requalification is required.
